// File: rtl/fpu_pipeline_controller.sv
// -----------------------------------------------------------------------------
// fpu_pipeline_controller
//
// Control sequencer for the pipelined FPU. It tracks per-stage occupancy and
// produces the single global stall that holds every pipeline register stage.
// A division parks in the divider stage for DIV_ITERATIONS recirculation
// cycles. Valid/ready handshakes are provided on the issue and result sides.
//
// Ports:
//   clk             in   clock
//   reset           in   asynchronous, active-high reset
//   flush           in   synchronous pipeline clear (drops the op presented)
//   issue_valid     in   new op presented at stage-0 inputs
//   issue_division  in   presented op is a division (qualified by issue_valid)
//   issue_ready     out  controller accepts the presented op this cycle
//   result_valid    out  last stage holds a completed op
//   result_ready    in   consumer accepts the result
//   stall           out  global hold for all stage registers
//   division_mode   out  divider stage recirculates this cycle
//   division_step   out  remaining divider iterations, counting down
//   stage_valid     out  occupancy bit per stage
//   pipeline_empty  out  no stage is occupied
// -----------------------------------------------------------------------------
module fpu_pipeline_controller #(
  parameter int STAGES         = 5,
  parameter int DIV_STAGE      = 2,
  parameter int DIV_ITERATIONS = 12,
  parameter int CW             = (DIV_ITERATIONS > 1) ? $clog2(DIV_ITERATIONS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              issue_valid,
  input  logic              issue_division,
  output logic              issue_ready,
  output logic              result_valid,
  input  logic              result_ready,
  output logic              stall,
  output logic              division_mode,
  output logic [CW-1:0]     division_step,
  output logic [STAGES-1:0] stage_valid,
  output logic              pipeline_empty
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ITER = 1'b1;

  // The division tag is only ever inspected at DIV_STAGE, which is never the
  // last stage, so the tag shift register stops one stage short.
  localparam int DW = STAGES - 1;

  logic [STAGES-1:0] stage_valid_q, stage_valid_d;
  logic [DW-1:0]     stage_div_q,   stage_div_d;
  logic [0:0]        state_q,       state_d;
  logic [CW-1:0]     cnt_q,         cnt_d;
  logic              div_done_q,    div_done_d;

  logic div_pending;
  logic div_stall;
  logic out_block;
  logic stall_int;
  logic fire;

  // Hold logic: an occupied division op in the divider stage that has not yet
  // finished its iterations, or an iteration in progress, freezes the pipe.
  // A full last stage the consumer is refusing also freezes it.
  always_comb begin
    div_pending = stage_valid_q[DIV_STAGE] & stage_div_q[DIV_STAGE] & ~div_done_q;
    div_stall   = div_pending | (state_q == ST_ITER);
    out_block   = stage_valid_q[STAGES-1] & ~result_ready;
    stall_int   = div_stall | out_block;
    fire        = issue_valid & ~stall_int;
  end

  always_comb begin
    // NOTE: every next-state variable gets a hold default first so that no
    // path through the block leaves it unassigned and infers a latch.
    stage_valid_d = stage_valid_q;
    stage_div_d   = stage_div_q;
    state_d       = state_q;
    cnt_d         = cnt_q;
    div_done_d    = div_done_q;

    if (!stall_int) begin
      stage_valid_d = {stage_valid_q[STAGES-2:0], fire};
      stage_div_d[0] = fire & issue_division;
      for (int i = 1; i < DW; i++) begin
        stage_div_d[i] = stage_div_q[i-1];
      end
      // Clearing on advance lets the next division entering the divider
      // stage start a fresh iteration run.
      div_done_d = 1'b0;
    end

    // The divider FSM runs independently of result_ready. While ITER is
    // active stall is high, so the advance clear above never coincides with
    // the done flag being set here.
    case (state_q)
      ST_IDLE: begin
        if (div_pending) begin
          state_d = ST_ITER;
          cnt_d   = CW'(DIV_ITERATIONS - 1);
        end
      end
      default: begin
        if (cnt_q == '0) begin
          state_d    = ST_IDLE;
          div_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
    endcase

    if (flush) begin
      stage_valid_d = '0;
      stage_div_d   = '0;
      state_d       = ST_IDLE;
      cnt_d         = '0;
      div_done_d    = 1'b0;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge values regardless of block order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_valid_q <= '0;
      stage_div_q   <= '0;
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      div_done_q    <= 1'b0;
    end else begin
      stage_valid_q <= stage_valid_d;
      stage_div_q   <= stage_div_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      div_done_q    <= div_done_d;
    end
  end

  // Outputs are pure functions of registered state and result_ready, so they
  // follow an asynchronous reset without waiting for a clock edge.
  always_comb begin
    stall          = stall_int;
    issue_ready    = ~stall_int;
    result_valid   = stage_valid_q[STAGES-1] & ~div_stall;
    division_mode  = (state_q == ST_ITER);
    division_step  = (state_q == ST_ITER) ? cnt_q : '0;
    stage_valid    = stage_valid_q;
    pipeline_empty = ~|stage_valid_q;
  end

endmodule

// File: tb/tb_fpu_pipeline_controller.sv
// -----------------------------------------------------------------------------
// tb_fpu_pipeline_controller
//
// Directed bench for fpu_pipeline_controller with default parameters.
// Stimulus processes drive inputs one cycle at a time and check per-cycle
// control outputs against hand-derived cycle windows. Each op issued also
// pushes its expected retirement cycle into a queue; an independent monitor
// pops that queue on every result handshake and compares the cycle number.
// -----------------------------------------------------------------------------
module tb_fpu_pipeline_controller;

  localparam int STAGES         = 5;
  localparam int DIV_STAGE      = 2;
  localparam int DIV_ITERATIONS = 12;
  localparam int CW             = 4;

  logic              clk;
  logic              reset;
  logic              flush;
  logic              issue_valid;
  logic              issue_division;
  logic              issue_ready;
  logic              result_valid;
  logic              result_ready;
  logic              stall;
  logic              division_mode;
  logic [CW-1:0]     division_step;
  logic [STAGES-1:0] stage_valid;
  logic              pipeline_empty;

  fpu_pipeline_controller #(
    .STAGES         (STAGES),
    .DIV_STAGE      (DIV_STAGE),
    .DIV_ITERATIONS (DIV_ITERATIONS)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .issue_valid    (issue_valid),
    .issue_division (issue_division),
    .issue_ready    (issue_ready),
    .result_valid   (result_valid),
    .result_ready   (result_ready),
    .stall          (stall),
    .division_mode  (division_mode),
    .division_step  (division_step),
    .stage_valid    (stage_valid),
    .pipeline_empty (pipeline_empty)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int t0     = 0;
  int exp_q[$];
  int mon_exp;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d from scenario start)",
               name, act, exp, cyc - t0);
    end
  endtask

  // Scoreboard monitor: every result handshake must match the oldest
  // outstanding expected retirement cycle.
  always @(negedge clk) begin
    if (!reset && result_valid && result_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL result_unexpected: got handshake at cycle %0d, expected none", cyc - t0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("result_cycle", cyc, mon_exp);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid    = 1'b0;
    issue_division = 1'b0;
    flush          = 1'b0;
    result_ready   = 1'b1;
  endtask

  task automatic drain(input int n);
    idle_inputs();
    for (int i = 0; i < n; i++) next_cycle();
    @(negedge clk);
    check("drain_empty", pipeline_empty, 1);
    next_cycle();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_stall"},          stall,          0);
    check({tag, "_issue_ready"},    issue_ready,    1);
    check({tag, "_result_valid"},   result_valid,   0);
    check({tag, "_division_mode"},  division_mode,  0);
    check({tag, "_division_step"},  division_step,  0);
    check({tag, "_stage_valid"},    stage_valid,    0);
    check({tag, "_pipeline_empty"}, pipeline_empty, 1);
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();

    // Reset values appear before any clock edge.
    #3;
    check_reset_outputs("reset_async");
    @(negedge clk);
    reset = 1'b0;
    next_cycle();

    // Reset release: quiet for 10 cycles.
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check_reset_outputs("reset_idle");
      next_cycle();
    end

    // Single add fired at cycle 0.
    t0 = cyc;
    exp_q.push_back(t0 + 5);
    for (int c = 0; c < 8; c++) begin
      issue_valid    = (c == 0);
      issue_division = 1'b0;
      @(negedge clk);
      check("add_stage_valid", stage_valid,
            (c >= 1 && c <= 5) ? (32'd1 << (c - 1)) : 32'd0);
      check("add_stall", stall, 0);
      check("add_result_valid", result_valid, (c == 5));
      next_cycle();
    end
    drain(2);

    // Single division fired at cycle 0.
    t0 = cyc;
    exp_q.push_back(t0 + 18);
    for (int c = 0; c < 20; c++) begin
      issue_valid    = (c == 0);
      issue_division = (c == 0);
      @(negedge clk);
      check("div_stall",        stall,         (c >= 3 && c <= 15));
      check("div_issue_ready",  issue_ready,   !(c >= 3 && c <= 15));
      check("div_mode",         division_mode, (c >= 4 && c <= 15));
      check("div_step",         division_step, (c >= 4 && c <= 15) ? 15 - c : 0);
      check("div_result_valid", result_valid,  (c == 18));
      next_cycle();
    end
    drain(2);

    // Three adds with the consumer refusing results until cycle 10.
    t0 = cyc;
    exp_q.push_back(t0 + 10);
    exp_q.push_back(t0 + 11);
    exp_q.push_back(t0 + 12);
    for (int c = 0; c < 14; c++) begin
      issue_valid    = (c <= 2);
      issue_division = 1'b0;
      result_ready   = (c >= 10);
      @(negedge clk);
      check("bp_result_valid", result_valid, (c >= 5 && c <= 12));
      check("bp_stall",        stall,        (c >= 5 && c <= 9));
      check("bp_issue_ready",  issue_ready,  !(c >= 5 && c <= 9));
      if (c >= 5 && c <= 9) check("bp_stage_hold", stage_valid, 5'b11100);
      next_cycle();
    end
    drain(2);

    // Two back-to-back divisions. The global stall raised by the second
    // division in stage 2 also freezes the first in stage 3, so the first
    // retires only once the pipe advances again after cycle 29.
    t0 = cyc;
    exp_q.push_back(t0 + 31);
    exp_q.push_back(t0 + 32);
    for (int c = 0; c < 35; c++) begin
      issue_valid    = (c <= 1);
      issue_division = (c <= 1);
      @(negedge clk);
      check("b2b_stall", stall, (c >= 3 && c <= 15) || (c >= 17 && c <= 29));
      check("b2b_mode",  division_mode, (c >= 4 && c <= 15) || (c >= 18 && c <= 29));
      check("b2b_step",  division_step,
            (c >= 4 && c <= 15) ? 15 - c : ((c >= 18 && c <= 29) ? 29 - c : 0));
      if (c == 17) check("b2b_stage17", stage_valid, 5'b01100);
      next_cycle();
    end
    drain(2);

    // Flush in cycle 8 during a division.
    t0 = cyc;
    for (int c = 0; c < 13; c++) begin
      issue_valid    = (c == 0) || (c == 8);
      issue_division = (c == 0) || (c == 8);
      flush          = (c == 8);
      @(negedge clk);
      if (c == 8) begin
        check("flush_pre_mode", division_mode, 1);
        check("flush_pre_step", division_step, 7);
      end
      if (c >= 9) begin
        check("flush_stage_valid", stage_valid,   0);
        check("flush_mode",        division_mode, 0);
        check("flush_stall",       stall,         0);
        check("flush_issue_ready", issue_ready,   1);
      end
      next_cycle();
    end
    drain(2);

    // Asynchronous reset pulse mid-iteration, between clock edges.
    t0 = cyc;
    for (int c = 0; c < 12; c++) begin
      issue_valid    = (c == 0);
      issue_division = (c == 0);
      @(negedge clk);
      if (c == 8) begin
        check("areset_pre_mode", division_mode, 1);
        #1 reset = 1'b1;
        #1 check_reset_outputs("areset_mid");
        #1 reset = 1'b0;
      end
      if (c >= 9) check_reset_outputs("areset_after");
      next_cycle();
    end
    drain(2);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
